// File: rtl/rr_grant_ctrl_pkg.sv
// Shared definitions for the round-robin grant controller.
// Contains the state encoding, the idle select pattern and the rotating-priority pick function.
package rr_grant_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] GNT_NONE_N = 4'b1111;

  // The search runs last+1, +2, +3, then last itself.
  // The loop walks that order backwards, so the earliest hit is written last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_sel_dec2to4_n.sv
// 2-to-4 active-low select decoder with enable.
// When the decoder is disabled, all four select lines are driven high.
module sel_dec2to4_n
  import rr_grant_ctrl_pkg::*;
(
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] sel_n
);

  always_comb begin
    sel_n = GNT_NONE_N;
    if (en) begin
      case (idx)
        2'd0:    sel_n = 4'b1110;
        2'd1:    sel_n = 4'b1101;
        2'd2:    sel_n = 4'b1011;
        default: sel_n = 4'b0111;
      endcase
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for four requesters, with a bounded hold time under contention.
// Every handover passes through one idle cycle, so a new owner never overlaps the previous one.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no owner; any request present at the edge is granted
//   ST_GRANT | gnt_idx owns the resource; hold_cnt counts the cycles it holds
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t        state;
  logic [1:0]    last_idx;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    winner;
  logic          contended;
  logic          release_own;

  always_comb begin
    winner      = rr_pick(req, last_idx);
    contended   = |(req & ~(4'b0001 << gnt_idx));
    release_own = !req[gnt_idx] || ((hold_cnt == HOLD_LAST) && contended);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= 2'd0;
      last_idx  <= 2'd3;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt_idx   <= winner;
            last_idx  <= winner;
            hold_cnt  <= '0;
            gnt_valid <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        default: begin
          if (release_own) begin
            gnt_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (hold_cnt != HOLD_LAST) begin
            // A sole requester keeps the grant; the counter just sits at its limit.
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  sel_dec2to4_n u_dec (
    .idx   (gnt_idx),
    .en    (gnt_valid),
    .sel_n (gnt_n)
  );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl, built with HOLD_MAX=4.
// A behavioural owner/last/cycle-count model supplies the expected value for each random cycle.
module tb_rr_grant_ctrl;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int passes = 0;

  int m_owner;
  int m_last;
  int m_cycles;

  rr_grant_ctrl #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner  = -1;
    m_last   = 3;
    m_cycles = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    bit         found;
    int         c;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && r[c]) begin
          found    = 1'b1;
          m_owner  = c;
          m_last   = c;
          m_cycles = 1;
        end
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (m_cycles >= HOLD_MAX && others != 4'b0000)) m_owner = -1;
      else m_cycles++;
    end
  endtask

  function automatic logic [3:0] model_gnt_n();
    logic [3:0] one;
    one = 4'b0001;
    if (m_owner < 0) return 4'b1111;
    return ~(one << m_owner);
  endfunction

  task automatic drive_cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Structural invariant on the outputs, checked every cycle.
  always @(negedge clk) begin
    logic [3:0] one;
    logic       bad;
    one = 4'b0001;
    bad = gnt_valid ? (gnt_n !== ~(one << gnt_idx)) : (gnt_n !== 4'b1111);
    checks++;
    if (bad) $display("FAIL invariant: gnt_n=%b gnt_valid=%b gnt_idx=%0d", gnt_n, gnt_valid, gnt_idx);
    else passes++;
  end

  task automatic test_reset();
    int n;
    req = 4'b1111;
    #1;
    checks++;
    if (gnt_n !== 4'b1111 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0)
      $display("FAIL reset_state: gnt_n=%b valid=%b idx=%0d want 1111/0/0", gnt_n, gnt_valid, gnt_idx);
    else passes++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (m_owner != 2 && n < 40) begin
      drive_cycle(4'b1111);
      n++;
    end
    checks++;
    if (m_owner != 2 || gnt_n !== 4'b1011)
      $display("FAIL reach_owner2: gnt_n=%b after %0d cycles want 1011", gnt_n, n);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_n !== 4'b1111 || gnt_valid !== 1'b0)
      $display("FAIL async_reset: gnt_n=%b valid=%b want 1111/0", gnt_n, gnt_valid);
    else passes++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(4'b1111);
    checks++;
    if (gnt_n !== 4'b1110 || gnt_idx !== 2'd0)
      $display("FAIL first_after_reset: gnt_n=%b idx=%0d want 1110/0", gnt_n, gnt_idx);
    else passes++;
  endtask

  task automatic test_single();
    drive_cycle(4'b0000);
    drive_cycle(4'b0000);
    checks++;
    if (gnt_n !== 4'b1111) $display("FAIL single_idle: gnt_n=%b want 1111", gnt_n);
    else passes++;
    drive_cycle(4'b0100);
    checks++;
    if (gnt_n !== 4'b1011 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1)
      $display("FAIL single_grant: gnt_n=%b idx=%0d valid=%b want 1011/2/1", gnt_n, gnt_idx, gnt_valid);
    else passes++;
    drive_cycle(4'b0000);
    checks++;
    if (gnt_n !== 4'b1111 || gnt_valid !== 1'b0)
      $display("FAIL single_release: gnt_n=%b valid=%b want 1111/0", gnt_n, gnt_valid);
    else passes++;
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    logic [3:0] one;
    int         pos;
    one = 4'b0001;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      drive_cycle(4'b1111);
      pos = (c - 1) % 5;
      exp = (pos == 4) ? 4'b1111 : ~(one << (((c - 1) / 5) % 4));
      checks++;
      if (gnt_n !== exp) $display("FAIL contention c%0d: gnt_n=%b want %b", c, gnt_n, exp);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      drive_cycle(4'b1001);
      exp = (c <= 4) ? 4'b1110 : (c == 5) ? 4'b1111 : 4'b0111;
      checks++;
      if (gnt_n !== exp) $display("FAIL wrap c%0d: gnt_n=%b want %b", c, gnt_n, exp);
      else passes++;
    end
    checks++;
    if (gnt_idx !== 2'd3) $display("FAIL wrap_idx: gnt_idx=%0d want 3", gnt_idx);
    else passes++;
  endtask

  task automatic test_solo();
    int bad;
    drive_cycle(4'b0000);
    drive_cycle(4'b0000);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(4'b0010);
      if (gnt_n !== 4'b1101) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL solo_hold: %0d of 20 cycles not 1101 want 0", bad);
    else passes++;
    drive_cycle(4'b0011);
    checks++;
    if (gnt_n !== 4'b1111) $display("FAIL solo_timeout: gnt_n=%b want 1111", gnt_n);
    else passes++;
    drive_cycle(4'b0011);
    checks++;
    if (gnt_n !== 4'b1110) $display("FAIL solo_next: gnt_n=%b want 1110", gnt_n);
    else passes++;
  endtask

  task automatic test_simultaneous();
    drive_cycle(4'b0000);
    drive_cycle(4'b0000);
    drive_cycle(4'b0010);
    drive_cycle(4'b0010);
    checks++;
    if (gnt_n !== 4'b1101) $display("FAIL simul_owner1: gnt_n=%b want 1101", gnt_n);
    else passes++;
    drive_cycle(4'b1000);
    checks++;
    if (gnt_n !== 4'b1111) $display("FAIL simul_gap: gnt_n=%b want 1111", gnt_n);
    else passes++;
    drive_cycle(4'b1000);
    checks++;
    if (gnt_n !== 4'b0111 || gnt_idx !== 2'd3)
      $display("FAIL simul_new: gnt_n=%b idx=%0d want 0111/3", gnt_n, gnt_idx);
    else passes++;
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] flip;
    logic [3:0] exp;
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      flip = 4'b0000;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(3) == 0);
      r = r ^ flip;
      drive_cycle(r);
      exp = model_gnt_n();
      checks++;
      if (gnt_n !== exp || gnt_valid !== (m_owner >= 0) ||
          (m_owner >= 0 && gnt_idx !== 2'(m_owner)))
        $display("FAIL random c%0d: req=%b gnt_n=%b valid=%b idx=%0d want gnt_n=%b owner=%0d",
                 c, r, gnt_n, gnt_valid, gnt_idx, exp, m_owner);
      else passes++;
      // Glitch between edges; drive_cycle restores the real value before the next edge.
      req = 4'($urandom);
      #2;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_solo();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
